// File: rtl/qos_pkg.sv
// qos_pkg: shared state encoding and default sizing for the QoS flow-control controller.
package qos_pkg;

    localparam int QOS_NUM_CH    = 4;
    localparam int QOS_MIN_PAUSE = 4;

    typedef enum logic [2:0] {
        RESET  = 3'd0,
        INIT   = 3'd1,
        IDLE   = 3'd2,
        ACTIVE = 3'd3,
        ERROR  = 3'd4
    } qos_state_t;

endpackage

// File: rtl/qos_ch_ctrl.sv
// qos_ch_ctrl: one virtual channel's pause/continue edge detect, hold timer and pending continue.
// QOS_PAUSE_CNT_EN adds a saturating pause event counter.
module qos_ch_ctrl #(
    parameter int MIN_PAUSE = 4,
    parameter int HOLD_W    = 3
`ifdef QOS_PAUSE_CNT_EN
    , parameter int CNT_W   = 8
`endif
) (
    input  logic CLK,
    input  logic reset,
    input  logic active_en,
    input  logic pause_i,
    input  logic cont_i,
    output logic pause_stb_o,
    output logic cont_stb_o,
    output logic paused_o,
    output logic pending_o
`ifdef QOS_PAUSE_CNT_EN
    , output logic [CNT_W-1:0] cnt_o
`endif
);

    logic              prev_p_q, prev_c_q;
    logic              pstb_q, pstb_d, cstb_q, cstb_d;
    logic              paused_q, paused_d, pending_q, pending_d;
    logic [HOLD_W-1:0] hold_q, hold_d, hold_dec;
    logic              p_rise, c_rise, expired;

    // expired means the hold reaches zero at this edge, so the earliest continue lands MIN_PAUSE cycles after the pause
    always_comb begin
        p_rise    = pause_i & ~prev_p_q;
        c_rise    = cont_i & ~prev_c_q;
        hold_dec  = (hold_q == '0) ? '0 : hold_q - HOLD_W'(1);
        expired   = (hold_dec == '0);
        pstb_d    = 1'b0;
        cstb_d    = 1'b0;
        paused_d  = paused_q;
        pending_d = pending_q;
        hold_d    = paused_q ? hold_dec : '0;
        if (!active_en) begin
            paused_d  = 1'b0;
            pending_d = 1'b0;
            hold_d    = '0;
        end else if (p_rise) begin
            hold_d = HOLD_W'(MIN_PAUSE);
            if (!paused_q) begin
                pstb_d    = 1'b1;
                paused_d  = 1'b1;
                pending_d = 1'b0;
            end
        end else if (paused_q && (c_rise || pending_q) && expired) begin
            cstb_d    = cont_i;
            paused_d  = ~cont_i;
            pending_d = 1'b0;
        end else if (paused_q && c_rise) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            prev_p_q  <= 1'b0;
            prev_c_q  <= 1'b0;
            pstb_q    <= 1'b0;
            cstb_q    <= 1'b0;
            paused_q  <= 1'b0;
            pending_q <= 1'b0;
            hold_q    <= '0;
        end else begin
            prev_p_q  <= pause_i;
            prev_c_q  <= cont_i;
            pstb_q    <= pstb_d;
            cstb_q    <= cstb_d;
            paused_q  <= paused_d;
            pending_q <= pending_d;
            hold_q    <= hold_d;
        end
    end

    assign pause_stb_o = pstb_q;
    assign cont_stb_o  = cstb_q;
    assign paused_o    = paused_q;
    assign pending_o   = pending_q;

`ifdef QOS_PAUSE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)
            cnt_q <= '0;
        else if (pstb_d && !(&cnt_q))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/qos_flow_fsm.sv
// qos_flow_fsm: QoS flow-control controller sequencing init/idle/active/error over NUM_CH channels.
// QOS_PAUSE_CNT_EN adds the packed per-channel pause_cnt output.
module qos_flow_fsm
    import qos_pkg::*;
#(
    parameter int NUM_CH    = QOS_NUM_CH,
    parameter int MIN_PAUSE = QOS_MIN_PAUSE,
    parameter int HOLD_W    = $clog2(MIN_PAUSE + 1)
`ifdef QOS_PAUSE_CNT_EN
    , parameter int CNT_W   = 8
`endif
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              set_init,
    input  logic [NUM_CH-1:0] empty,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] pause_fifos,
    input  logic [NUM_CH-1:0] continue_fifos,
    output logic              init,
    output logic              idle,
    output logic [NUM_CH-1:0] pause_stb,
    output logic [NUM_CH-1:0] continue_stb,
    output logic [NUM_CH-1:0] error_full,
    output logic [NUM_CH-1:0] paused
`ifdef QOS_PAUSE_CNT_EN
    , output logic [NUM_CH*CNT_W-1:0] pause_cnt
`endif
);

    qos_state_t        state_q, state_d;
    logic              init_q, init_d, idle_q, idle_d;
    logic [NUM_CH-1:0] error_full_q, error_full_d;
    logic [NUM_CH-1:0] pending;
    logic              active_en;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q      <= RESET;
            init_q       <= 1'b0;
            idle_q       <= 1'b0;
            error_full_q <= '0;
        end else begin
            state_q      <= state_d;
            init_q       <= init_d;
            idle_q       <= idle_d;
            error_full_q <= error_full_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RESET:   state_d = INIT;
            INIT:    state_d = set_init ? INIT : IDLE;
            IDLE:    state_d = (|full) ? ERROR : (~&empty) ? ACTIVE : IDLE;
            ACTIVE:  state_d = (|full) ? ERROR
                             : (&empty && !(|paused) && !(|pending)) ? IDLE : ACTIVE;
            ERROR:   state_d = ERROR;
            default: state_d = RESET;
        endcase
    end

    // Outputs track the state being entered; the transition edge into ERROR already captures its full flags
    always_comb begin
        init_d       = (state_d == INIT) && set_init;
        idle_d       = (state_d == IDLE) && (&empty);
        error_full_d = error_full_q | ((state_d == ERROR) ? full : '0);
        active_en    = (state_q == ACTIVE) && (state_d == ACTIVE);
    end

    assign init       = init_q;
    assign idle       = idle_q;
    assign error_full = error_full_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        qos_ch_ctrl #(
            .MIN_PAUSE (MIN_PAUSE),
            .HOLD_W    (HOLD_W)
`ifdef QOS_PAUSE_CNT_EN
            , .CNT_W   (CNT_W)
`endif
        ) u_ch (
            .CLK         (CLK),
            .reset       (reset),
            .active_en   (active_en),
            .pause_i     (pause_fifos[i]),
            .cont_i      (continue_fifos[i]),
            .pause_stb_o (pause_stb[i]),
            .cont_stb_o  (continue_stb[i]),
            .paused_o    (paused[i]),
            .pending_o   (pending[i])
`ifdef QOS_PAUSE_CNT_EN
            , .cnt_o     (pause_cnt[i*CNT_W +: CNT_W])
`endif
        );
    end

endmodule
